// File: rtl/imem_arbiter.sv
// Shares the instruction memory between core fetch and a debug/loader port; grants are combinational, responses one cycle later.
// There is no backpressure: the loser simply sees no grant, and a debug request that keeps losing is forced through after MAX_WAIT cycles.
module imem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   input  logic              dbg_halt_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              halted_o,
   output logic              hold_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   typedef struct packed {
      logic vld;
      logic owner;   // 1 = debug, 0 = fetch
      logic wr;
   } tag_t;

   localparam logic [3:0] MAX_W = MAX_WAIT[3:0];

   state_t     state, state_nxt;
   tag_t       tag, tag_nxt;
   logic [3:0] wait_cnt, wait_cnt_nxt;

   always_comb begin
      state_nxt    = state;
      if_gnt_o     = 1'b0;
      dbg_gnt_o    = 1'b0;
      wait_cnt_nxt = 4'd0;
      case (state)
         RUN: begin
            dbg_gnt_o = dbg_req_i & (~if_req_i | (wait_cnt == MAX_W));
            if_gnt_o  = if_req_i & ~dbg_gnt_o;
            if (dbg_req_i && !dbg_gnt_o)
               wait_cnt_nxt = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;
            if (dbg_halt_i)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            // No grants are issued here, so any fetch response in flight on entry completes this cycle.
            if (!dbg_halt_i)
               state_nxt = RUN;
            else if (!(tag_nxt.vld && !tag_nxt.owner))
               state_nxt = HALTED;
         end
         HALTED: begin
            dbg_gnt_o = dbg_req_i;
            if (!dbg_halt_i)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
      // Grants stay low while reset is asserted so every output reads 0.
      if (!rst) begin
         if_gnt_o  = 1'b0;
         dbg_gnt_o = 1'b0;
      end
   end

   always_comb begin
      tag_nxt.vld   = if_gnt_o | dbg_gnt_o;
      tag_nxt.owner = dbg_gnt_o;
      tag_nxt.wr    = dbg_gnt_o & dbg_we_i;
   end

   always_comb begin
      mem_ce_o    = if_gnt_o | dbg_gnt_o;
      mem_we_o    = dbg_gnt_o & dbg_we_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (dbg_gnt_o) begin
         mem_addr_o  = dbg_addr_i;
         mem_wdata_o = dbg_wdata_i;
      end else if (if_gnt_o) begin
         mem_addr_o  = if_addr_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         tag      <= '0;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         tag      <= tag_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      if_rvalid_o  = tag.vld & ~tag.owner;
      dbg_rvalid_o = tag.vld & tag.owner;
      if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
      dbg_rdata_o  = (dbg_rvalid_o && !tag.wr) ? mem_rdata_i : '0;
      hold_o       = (state != RUN);
      halted_o     = (state == HALTED);
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small synchronous memory behind it.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i, dbg_req_i, dbg_we_i, dbg_halt_i;
   logic [31:0] if_addr_i, dbg_addr_i, dbg_wdata_i;
   logic        if_gnt_o, if_rvalid_o, dbg_gnt_o, dbg_rvalid_o, halted_o, hold_o;
   logic [31:0] if_rdata_o, dbg_rdata_o;
   logic        mem_ce_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [64];

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_halt_i(dbg_halt_i), .dbg_gnt_o(dbg_gnt_o),
      .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
      .halted_o(halted_o), .hold_o(hold_o),
      .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always @(posedge clk) begin
      if (mem_ce_o) begin
         if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
         else          mem_rdata_i <= mem[mem_addr_o[7:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
      mem_rdata_i = '0;

      // Reset with every request high
      rst = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h0;
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h4; dbg_wdata_i = 32'hFFFF_FFFF;
      dbg_halt_i = 1'b1;
      repeat (3) begin
         tick();
         chk("rst_outs", {28'd0, if_gnt_o, dbg_gnt_o, if_rvalid_o, dbg_rvalid_o}, 32'd0);
         chk("rst_misc", {26'd0, halted_o, hold_o, mem_ce_o, mem_we_o, 2'b00}, 32'd0);
         chk("rst_addr", mem_addr_o | mem_wdata_o | if_rdata_o | dbg_rdata_o, 32'd0);
      end

      // Release with fetch only
      rst = 1'b1; dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_halt_i = 1'b0; dbg_wdata_i = '0;
      #1;
      chk("first_if_gnt", {31'd0, if_gnt_o}, 32'd1);
      chk("first_ce_we", {30'd0, mem_ce_o, mem_we_o}, 32'd2);
      chk("first_addr", mem_addr_o, 32'h0);
      tick();
      if_req_i = 1'b0; #1;
      chk("first_rvalid", {31'd0, if_rvalid_o}, 32'd1);
      chk("first_rdata", if_rdata_o, 32'hA000_0000);
      chk("first_idle_ce", {31'd0, mem_ce_o}, 32'd0);
      tick();
      chk("first_rvalid_clr", {31'd0, if_rvalid_o}, 32'd0);

      // Starvation: fetch hogs the memory, dbg forced through on its 5th cycle
      if_req_i = 1'b1; if_addr_i = 32'h4;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h40;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk("starve_dbg_lose", {31'd0, dbg_gnt_o}, 32'd0);
         chk("starve_if_win", {31'd0, if_gnt_o}, 32'd1);
         tick();
      end
      #1;
      chk("starve_dbg_win", {30'd0, dbg_gnt_o, if_gnt_o}, 32'd2);
      chk("starve_mem_addr", mem_addr_o, 32'h40);
      tick();
      dbg_req_i = 1'b0; #1;
      chk("starve_dbg_rvalid", {30'd0, dbg_rvalid_o, if_rvalid_o}, 32'd2);
      chk("starve_dbg_rdata", dbg_rdata_o, 32'hA000_0010);
      tick();

      // dbg wins immediately when fetch is idle
      if_req_i = 1'b0; dbg_req_i = 1'b1; dbg_addr_i = 32'h8; #1;
      chk("idle_dbg_gnt", {31'd0, dbg_gnt_o}, 32'd1);
      tick();
      dbg_req_i = 1'b0; #1;
      chk("idle_dbg_rdata", dbg_rdata_o, 32'hA000_0002);
      tick();

      // Halt requested in the same cycle as a fetch grant
      if_req_i = 1'b1; if_addr_i = 32'h4; dbg_halt_i = 1'b1; #1;
      chk("halt_N_if_gnt", {31'd0, if_gnt_o}, 32'd1);
      chk("halt_N_hold", {31'd0, hold_o}, 32'd0);
      tick();
      #1;
      chk("drain_hold", {30'd0, hold_o, halted_o}, 32'd2);
      chk("drain_if_gnt", {31'd0, if_gnt_o}, 32'd0);
      chk("drain_if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
      chk("drain_if_rdata", if_rdata_o, 32'hA000_0001);
      tick();
      chk("halted", {30'd0, hold_o, halted_o}, 32'd3);

      // Load and verify in HALTED; fetch request stays high and must be ignored
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h8; dbg_wdata_i = 32'h0010_0093; #1;
      chk("wr_gnt", {30'd0, dbg_gnt_o, if_gnt_o}, 32'd2);
      chk("wr_we", {31'd0, mem_we_o}, 32'd1);
      chk("wr_wdata", mem_wdata_o, 32'h0010_0093);
      tick();
      dbg_we_i = 1'b0; dbg_wdata_i = '0; #1;
      chk("rd_gnt_we", {30'd0, dbg_gnt_o, mem_we_o}, 32'd2);
      chk("wr_ack", {31'd0, dbg_rvalid_o}, 32'd1);
      chk("wr_ack_rdata", dbg_rdata_o, 32'h0);
      tick();
      dbg_req_i = 1'b0; #1;
      chk("rd_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      chk("rd_rdata", dbg_rdata_o, 32'h0010_0093);
      chk("halt_idle_ce", {30'd0, mem_ce_o, if_gnt_o}, 32'd0);
      tick();

      // Release with a dbg read in the final HALTED cycle
      dbg_halt_i = 1'b0; dbg_req_i = 1'b1; dbg_addr_i = 32'h40; if_addr_i = 32'h8; #1;
      chk("last_halt_gnt", {29'd0, dbg_gnt_o, if_gnt_o, halted_o}, 32'd5);
      tick();
      dbg_req_i = 1'b0; #1;
      chk("run_hold", {30'd0, hold_o, halted_o}, 32'd0);
      chk("run_dbg_rsp", {30'd0, dbg_rvalid_o, if_gnt_o}, 32'd3);
      chk("run_dbg_rdata", dbg_rdata_o, 32'hA000_0010);
      chk("run_if_addr", mem_addr_o, 32'h8);
      tick();
      if_req_i = 1'b0; #1;
      chk("run_if_rdata", if_rdata_o, 32'h0010_0093);
      tick();

      // Asynchronous reset between grant and response
      if_req_i = 1'b1; if_addr_i = 32'h0; #1;
      chk("arst_pre_gnt", {31'd0, if_gnt_o}, 32'd1);
      #2 rst = 1'b0; #1;
      chk("arst_clear", {29'd0, if_gnt_o, mem_ce_o, if_rvalid_o}, 32'd0);
      tick();
      chk("arst_no_rvalid", {30'd0, if_rvalid_o, dbg_rvalid_o}, 32'd0);
      if_req_i = 1'b0; rst = 1'b1;
      tick();
      chk("arst_after", {30'd0, if_rvalid_o, dbg_rvalid_o}, 32'd0);
      tick();
      chk("arst_after2", {30'd0, if_rvalid_o, dbg_rvalid_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
